alu_result_collector: RTL and testbench
=======================================

# alu_result_collector

Downstream stage of the signed ALU: it consumes the four registered unit outputs and their flags, and selects the single active result each cycle. It widens that result to a common format and queues it in a small FIFO, which drains through a valid/ready handshake. It decouples the ALU's fire-every-cycle output from a consumer that may stall. It also reports overflow and flag-collision errors.

## Interface
- IN_DATA_WIDTH, 16, operand width of the ALU (W); logic/CMP/shift results are W bits
- OUT_DATA_WIDTH, 2*IN_DATA_WIDTH, width of queued result (arith width)
- FIFO_DEPTH, 4, entries; power of two, ≥2
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- Arith_OUT  in  OUT_DATA_WIDTH  signed arithmetic result
- Carry_OUT  in  1  arithmetic carry
- Arith_Flag  in  1  Arith_OUT valid this cycle
- Logic_OUT / CMP_OUT / Shift_OUT  in  IN_DATA_WIDTH each  unit results
- Logic_Flag / CMP_Flag / Shift_Flag  in  1 each  matching result valid this cycle
- RES_DATA  out  OUT_DATA_WIDTH  head-of-queue result
- RES_CARRY  out  1  head-of-queue carry (0 for non-arith)
- RES_TYPE  out  2  head-of-queue source unit code
- RES_VALID  out  1  queue non-empty
- RES_READY  in  1  consumer accepts head this cycle
- CLR_ERR  in  1  synchronous clear of sticky error bits
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  occupancy
- OVERFLOW  out  1  sticky: a valid result was dropped because the queue was full
- MULTI_ERR  out  1  sticky: more than one flag was high in one cycle

## Operation
- Selection priority when several flags are high: Arith > Logic > CMP > Shift. The highest wins. MULTI_ERR is set.
- Type codes: Arith 2'b00, Logic 2'b01, CMP 2'b10, Shift 2'b11. They match ALU_FUN[3:2].
- Width rule: Arith is stored as-is. Logic/CMP/Shift are zero-extended to OUT_DATA_WIDTH. Carry is stored only for Arith, otherwise 0.
- Push: any flag high. Pop: RES_VALID && RES_READY.
- FIFO is first-word fall-through. RES_DATA/RES_CARRY/RES_TYPE are driven from the entry at the read pointer.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- Full with no pop: the push is dropped and OVERFLOW sets. Contents are unchanged.
- Full with a simultaneous pop: the push is accepted and the count is unchanged.
- Empty: a pop is impossible because RES_VALID=0. A push and RES_READY in the same cycle do not bypass; the entry appears next cycle.
- CLR_ERR clears OVERFLOW and MULTI_ERR at the next edge. An error event in the same cycle as CLR_ERR wins: the bit stays 1.
- RES_DATA/RES_CARRY/RES_TYPE are undefined-but-stable while RES_VALID=0. The bench must not check them then.

## Timing
- Reset (RST=0, async): pointers 0, FIFO_COUNT 0, RES_VALID 0, OVERFLOW 0, MULTI_ERR 0, RES_DATA/RES_CARRY/RES_TYPE 0. Queued contents are discarded, including on reset mid-stream.
- Latency: a flag sampled at edge k gives RES_VALID=1 with that data after edge k (1 cycle).
- Throughput: 1 push and 1 pop per cycle sustained.
- FIFO_COUNT is registered and updates at the same edge as the pointers.
- Sticky errors are visible after the edge that detected the event.

## Structure
- Shared package alu_pkg holds:
  - the result type codes (localparams ARITH_T, LOGIC_T, CMP_T, SHIFT_T);
  - the entry layout (data, carry, type).
- Sub-module result_fifo is parameterised by width and depth. It provides FWFT, count, full, empty, and push-when-full-with-pop.
- The top level holds the priority select, widening, and sticky error logic.

## Test plan
- Reset, then Arith_Flag=1 with Arith_OUT=-3 (0xFFFFFFFD) and Carry_OUT=1, RES_READY=0 -> after 1 edge: RES_VALID=1, RES_DATA=0xFFFFFFFD, RES_CARRY=1, RES_TYPE=00, FIFO_COUNT=1.
- Push Logic 0x00F0, CMP 0x0001, Shift 0x8000 on consecutive cycles, then RES_READY=1 -> pop order is 0x000000F0/01, 0x00000001/10, 0x00008000/11, all with RES_CARRY=0. RES_VALID falls after the third pop.
- RES_READY=0 and 5 pushes with DEPTH=4 -> FIFO_COUNT=4 and OVERFLOW=1 after the 5th edge. The first 4 values drain intact. CLR_ERR for 1 cycle -> OVERFLOW=0.
- Full queue, push and RES_READY=1 in the same cycle -> FIFO_COUNT stays 4, OVERFLOW stays 0, and the new entry emerges 4th.
- Arith_Flag=1 and Shift_Flag=1 together -> the Arith value is queued (type 00) and MULTI_ERR=1. RST pulsed low mid-cycle with 3 entries queued -> RES_VALID=0, FIFO_COUNT=0, and errors are 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: source-unit type codes and the
// side-band fields stored next to each queued result.
package alu_pkg;

    // Source unit codes; these line up with ALU_FUN[3:2].
    localparam logic [1:0] ARITH_T = 2'b00;
    localparam logic [1:0] LOGIC_T = 2'b01;
    localparam logic [1:0] CMP_T   = 2'b10;
    localparam logic [1:0] SHIFT_T = 2'b11;

    // Per-entry side-band: carry (arith only) and source type.
    // A queue entry is {data, res_meta_t} with data in the upper bits.
    typedef struct packed {
        logic       carry;
        logic [1:0] rtype;
    } res_meta_t;

    localparam int unsigned META_W = $bits(res_meta_t);

endpackage : alu_pkg

// File: rtl/result_fifo.sv
// First-word fall-through FIFO with registered occupancy count. A push while
// full is accepted only when a pop happens in the same cycle.
module result_fifo #(
    parameter int unsigned Width = 35,
    parameter int unsigned Depth = 4,
    localparam int unsigned AddrW = $clog2(Depth),
    localparam int unsigned PtrW  = AddrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PtrW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Full/empty from the extra pointer MSB; accept/ptr/count next-state.
    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                   (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
        pop_ok   = pop_i && !empty_o;
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + PtrW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - PtrW'(1);
        end
    end

    // Pointer and count registers; reset discards any queued contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared on reset so the head reads 0 straight out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];
    assign count_o = count_q;

endmodule : result_fifo

// File: rtl/alu_result_collector.sv
// Collects the single active ALU unit result each cycle, widens it to the
// arithmetic width and queues it for a valid/ready consumer. Reports dropped
// results and flag collisions through sticky error bits.
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int unsigned IN_DATA_WIDTH  = 16,
    parameter int unsigned OUT_DATA_WIDTH = 2 * IN_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH     = 4,
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [OUT_DATA_WIDTH-1:0] Arith_OUT,
    input  logic                      Carry_OUT,
    input  logic                      Arith_Flag,
    input  logic [IN_DATA_WIDTH-1:0]  Logic_OUT,
    input  logic                      Logic_Flag,
    input  logic [IN_DATA_WIDTH-1:0]  CMP_OUT,
    input  logic                      CMP_Flag,
    input  logic [IN_DATA_WIDTH-1:0]  Shift_OUT,
    input  logic                      Shift_Flag,
    output logic [OUT_DATA_WIDTH-1:0] RES_DATA,
    output logic                      RES_CARRY,
    output logic [1:0]                RES_TYPE,
    output logic                      RES_VALID,
    input  logic                      RES_READY,
    input  logic                      CLR_ERR,
    output logic [CntW-1:0]           FIFO_COUNT,
    output logic                      OVERFLOW,
    output logic                      MULTI_ERR
);

    localparam int unsigned EntryW = OUT_DATA_WIDTH + META_W;
    localparam int unsigned PadW   = OUT_DATA_WIDTH - IN_DATA_WIDTH;

    logic [OUT_DATA_WIDTH-1:0] sel_data;
    res_meta_t                 sel_meta;
    res_meta_t                 head_meta;
    logic [EntryW-1:0]         wr_entry;
    logic [EntryW-1:0]         rd_entry;
    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      multi_evt;
    logic                      ovf_evt;
    logic                      overflow_q, overflow_d;
    logic                      multi_q, multi_d;

    // Priority select Arith > Logic > CMP > Shift, zero-extending narrow units.
    always_comb begin
        sel_data       = '0;
        sel_meta.carry = 1'b0;
        sel_meta.rtype = SHIFT_T;
        if (Arith_Flag) begin
            sel_data       = Arith_OUT;
            sel_meta.carry = Carry_OUT;
            sel_meta.rtype = ARITH_T;
        end else if (Logic_Flag) begin
            sel_data       = {{PadW{1'b0}}, Logic_OUT};
            sel_meta.rtype = LOGIC_T;
        end else if (CMP_Flag) begin
            sel_data       = {{PadW{1'b0}}, CMP_OUT};
            sel_meta.rtype = CMP_T;
        end else if (Shift_Flag) begin
            sel_data       = {{PadW{1'b0}}, Shift_OUT};
            sel_meta.rtype = SHIFT_T;
        end
    end

    // Handshake and error-event detection; a set event beats a same-cycle clear.
    always_comb begin
        push       = Arith_Flag | Logic_Flag | CMP_Flag | Shift_Flag;
        pop        = RES_VALID & RES_READY;
        multi_evt  = (32'(Arith_Flag) + 32'(Logic_Flag) + 32'(CMP_Flag) +
                      32'(Shift_Flag)) > 32'd1;
        ovf_evt    = push & fifo_full & ~pop;
        overflow_d = (overflow_q & ~CLR_ERR) | ovf_evt;
        multi_d    = (multi_q & ~CLR_ERR) | multi_evt;
    end

    // Sticky error registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow_q <= 1'b0;
            multi_q    <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            multi_q    <= multi_d;
        end
    end

    assign wr_entry = {sel_data, sel_meta};

    result_fifo #(
        .Width (EntryW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (FIFO_COUNT)
    );

    assign head_meta = res_meta_t'(rd_entry[META_W-1:0]);
    assign RES_DATA  = rd_entry[EntryW-1:META_W];
    assign RES_CARRY = head_meta.carry;
    assign RES_TYPE  = head_meta.rtype;
    assign RES_VALID = ~fifo_empty;
    assign OVERFLOW  = overflow_q;
    assign MULTI_ERR = multi_q;

endmodule : alu_result_collector

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector (W=16, depth 4). Inputs change 1ns
// after the rising edge; outputs are checked at that same point.
module tb_alu_result_collector;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Arith_OUT;
    logic        Carry_OUT, Arith_Flag;
    logic [15:0] Logic_OUT, CMP_OUT, Shift_OUT;
    logic        Logic_Flag, CMP_Flag, Shift_Flag;
    logic [31:0] RES_DATA;
    logic        RES_CARRY;
    logic [1:0]  RES_TYPE;
    logic        RES_VALID, RES_READY, CLR_ERR;
    logic [2:0]  FIFO_COUNT;
    logic        OVERFLOW, MULTI_ERR;

    int total = 0;
    int bad   = 0;

    alu_result_collector #(
        .IN_DATA_WIDTH  (16),
        .OUT_DATA_WIDTH (32),
        .FIFO_DEPTH     (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Arith_OUT  (Arith_OUT),
        .Carry_OUT  (Carry_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_OUT  (Logic_OUT),
        .Logic_Flag (Logic_Flag),
        .CMP_OUT    (CMP_OUT),
        .CMP_Flag   (CMP_Flag),
        .Shift_OUT  (Shift_OUT),
        .Shift_Flag (Shift_Flag),
        .RES_DATA   (RES_DATA),
        .RES_CARRY  (RES_CARRY),
        .RES_TYPE   (RES_TYPE),
        .RES_VALID  (RES_VALID),
        .RES_READY  (RES_READY),
        .CLR_ERR    (CLR_ERR),
        .FIFO_COUNT (FIFO_COUNT),
        .OVERFLOW   (OVERFLOW),
        .MULTI_ERR  (MULTI_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        Arith_Flag = 0; Logic_Flag = 0; CMP_Flag = 0; Shift_Flag = 0;
        Carry_OUT = 0; CLR_ERR = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RES_READY = 0; Arith_OUT = '0; Logic_OUT = '0; CMP_OUT = '0; Shift_OUT = '0;
        RST = 0;
        #12;
        RST = 1;
        cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        RES_READY = 0;
        RST = 0;
        #3;
        total++;
        if ({RES_VALID, FIFO_COUNT, OVERFLOW, MULTI_ERR} !== 6'b0) begin
            bad++;
            $display("FAIL reset_status got v=%b c=%0d o=%b m=%b want all 0",
                     RES_VALID, FIFO_COUNT, OVERFLOW, MULTI_ERR);
        end
        total++;
        if ({RES_DATA, RES_CARRY, RES_TYPE} !== 35'h0) begin
            bad++;
            $display("FAIL reset_head got d=%h c=%b t=%b want 0", RES_DATA, RES_CARRY,
                     RES_TYPE);
        end
        #9;
        RST = 1;
        cycle();
    endtask

    task automatic test_arith();
        Arith_Flag = 1; Arith_OUT = 32'hFFFF_FFFD; Carry_OUT = 1;
        cycle();
        idle_inputs();
        total++;
        if ({RES_VALID, RES_DATA, RES_CARRY, RES_TYPE, FIFO_COUNT} !==
            {1'b1, 32'hFFFF_FFFD, 1'b1, 2'b00, 3'd1}) begin
            bad++;
            $display("FAIL arith_push got v=%b d=%h c=%b t=%b n=%0d want 1 fffffffd 1 00 1",
                     RES_VALID, RES_DATA, RES_CARRY, RES_TYPE, FIFO_COUNT);
        end
        RES_READY = 1;
        cycle();
        RES_READY = 0;
        total++;
        if (RES_VALID !== 1'b0 || FIFO_COUNT !== 3'd0) begin
            bad++;
            $display("FAIL arith_pop got v=%b n=%0d want 0 0", RES_VALID, FIFO_COUNT);
        end
    endtask

    task automatic test_order();
        logic [31:0] exp_d [3] = '{32'h0000_00F0, 32'h0000_0001, 32'h0000_8000};
        logic [1:0]  exp_t [3] = '{2'b01, 2'b10, 2'b11};
        Logic_Flag = 1; Logic_OUT = 16'h00F0; cycle(); Logic_Flag = 0;
        CMP_Flag = 1;   CMP_OUT = 16'h0001;   cycle(); CMP_Flag = 0;
        Shift_Flag = 1; Shift_OUT = 16'h8000; cycle(); Shift_Flag = 0;
        total++;
        if (FIFO_COUNT !== 3'd3) begin
            bad++;
            $display("FAIL order_count got %0d want 3", FIFO_COUNT);
        end
        RES_READY = 1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({RES_VALID, RES_DATA, RES_CARRY, RES_TYPE} !== {1'b1, exp_d[i], 1'b0, exp_t[i]})
            begin
                bad++;
                $display("FAIL order_pop%0d got v=%b d=%h c=%b t=%b want 1 %h 0 %b", i,
                         RES_VALID, RES_DATA, RES_CARRY, RES_TYPE, exp_d[i], exp_t[i]);
            end
            cycle();
        end
        RES_READY = 0;
        total++;
        if (RES_VALID !== 1'b0) begin
            bad++;
            $display("FAIL order_empty got v=%b want 0", RES_VALID);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            Logic_Flag = 1; Logic_OUT = 16'(i);
            cycle();
            if (i == 4) begin
                total++;
                if (OVERFLOW !== 1'b0 || FIFO_COUNT !== 3'd4) begin
                    bad++;
                    $display("FAIL ovf_fill got o=%b n=%0d want 0 4", OVERFLOW, FIFO_COUNT);
                end
            end
        end
        Logic_Flag = 0;
        total++;
        if (OVERFLOW !== 1'b1 || FIFO_COUNT !== 3'd4) begin
            bad++;
            $display("FAIL ovf_set got o=%b n=%0d want 1 4", OVERFLOW, FIFO_COUNT);
        end
        RES_READY = 1;
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (RES_VALID !== 1'b1 || RES_DATA !== 32'(i)) begin
                bad++;
                $display("FAIL ovf_drain%0d got v=%b d=%h want 1 %h", i, RES_VALID, RES_DATA,
                         32'(i));
            end
            cycle();
        end
        RES_READY = 0;
        total++;
        if (RES_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin
            bad++;
            $display("FAIL ovf_after got v=%b o=%b want 0 1", RES_VALID, OVERFLOW);
        end
        CLR_ERR = 1; cycle(); CLR_ERR = 0;
        total++;
        if (OVERFLOW !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear got %b want 0", OVERFLOW);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            CMP_Flag = 1; CMP_OUT = 16'h11 + 16'(i);
            cycle();
        end
        total++;
        if (FIFO_COUNT !== 3'd4) begin
            bad++;
            $display("FAIL fullpop_fill got %0d want 4", FIFO_COUNT);
        end
        CMP_OUT = 16'h15; RES_READY = 1;
        cycle();
        CMP_Flag = 0;
        total++;
        if (FIFO_COUNT !== 3'd4 || OVERFLOW !== 1'b0) begin
            bad++;
            $display("FAIL fullpop_keep got n=%0d o=%b want 4 0", FIFO_COUNT, OVERFLOW);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (RES_VALID !== 1'b1 || RES_DATA !== 32'h12 + 32'(i) || RES_TYPE !== 2'b10) begin
                bad++;
                $display("FAIL fullpop_drain%0d got v=%b d=%h t=%b want 1 %h 10", i, RES_VALID,
                         RES_DATA, RES_TYPE, 32'h12 + 32'(i));
            end
            cycle();
        end
        RES_READY = 0;
        total++;
        if (RES_VALID !== 1'b0) begin
            bad++;
            $display("FAIL fullpop_empty got v=%b want 0", RES_VALID);
        end
    endtask

    task automatic test_back_to_back();
        // Push into an empty queue with ready high: no bypass, entry shows next cycle.
        RES_READY = 1;
        for (int i = 0; i < 4; i++) begin
            Shift_Flag = 1; Shift_OUT = 16'hA0 + 16'(i);
            cycle();
            total++;
            if (RES_VALID !== 1'b1 || FIFO_COUNT !== 3'd1 || RES_DATA !== 32'hA0 + 32'(i)) begin
                bad++;
                $display("FAIL b2b_%0d got v=%b n=%0d d=%h want 1 1 %h", i, RES_VALID,
                         FIFO_COUNT, RES_DATA, 32'hA0 + 32'(i));
            end
        end
        Shift_Flag = 0;
        cycle();
        RES_READY = 0;
        total++;
        if (RES_VALID !== 1'b0 || FIFO_COUNT !== 3'd0) begin
            bad++;
            $display("FAIL b2b_end got v=%b n=%0d want 0 0", RES_VALID, FIFO_COUNT);
        end
    endtask

    task automatic test_multi_reset();
        Arith_Flag = 1; Arith_OUT = 32'h1234_5678; Carry_OUT = 0;
        Shift_Flag = 1; Shift_OUT = 16'hBEEF;
        cycle();
        idle_inputs();
        total++;
        if (RES_DATA !== 32'h1234_5678 || RES_TYPE !== 2'b00 || MULTI_ERR !== 1'b1) begin
            bad++;
            $display("FAIL multi_sel got d=%h t=%b m=%b want 12345678 00 1", RES_DATA, RES_TYPE,
                     MULTI_ERR);
        end
        // Collision in the same cycle as a clear keeps the bit set.
        CLR_ERR = 1; Logic_Flag = 1; CMP_Flag = 1; Logic_OUT = 16'h7; CMP_OUT = 16'h8;
        cycle();
        idle_inputs();
        total++;
        if (MULTI_ERR !== 1'b1 || FIFO_COUNT !== 3'd2 || OVERFLOW !== 1'b0) begin
            bad++;
            $display("FAIL multi_clr_race got m=%b n=%0d o=%b want 1 2 0", MULTI_ERR,
                     FIFO_COUNT, OVERFLOW);
        end
        CLR_ERR = 1; cycle(); CLR_ERR = 0;
        total++;
        if (MULTI_ERR !== 1'b0) begin
            bad++;
            $display("FAIL multi_clear got %b want 0", MULTI_ERR);
        end
        CMP_Flag = 1; Shift_Flag = 1; cycle(); idle_inputs();
        total++;
        if (FIFO_COUNT !== 3'd3 || MULTI_ERR !== 1'b1) begin
            bad++;
            $display("FAIL multi_again got n=%0d m=%b want 3 1", FIFO_COUNT, MULTI_ERR);
        end
        #3;
        RST = 0;
        #1;
        total++;
        if ({RES_VALID, FIFO_COUNT, OVERFLOW, MULTI_ERR} !== 6'b0) begin
            bad++;
            $display("FAIL midreset got v=%b n=%0d o=%b m=%b want 0 0 0 0", RES_VALID,
                     FIFO_COUNT, OVERFLOW, MULTI_ERR);
        end
        #3;
        RST = 1;
        cycle();
        total++;
        if (RES_VALID !== 1'b0 || FIFO_COUNT !== 3'd0) begin
            bad++;
            $display("FAIL postreset got v=%b n=%0d want 0 0", RES_VALID, FIFO_COUNT);
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_arith();
        test_order();
        test_overflow();
        test_full_pop();
        test_back_to_back();
        test_multi_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so a stuck run still ends.
    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule : tb_alu_result_collector
